edge_detect: RTL and testbench
==============================

// Module: edge_detect
//
// PURPOSE
// - Single-clock rising/falling edge detector for a possibly asynchronous level input.
// - Synchronises sig_in into the clk domain through a flop chain, then compares the
//   current and previous synchronised levels.
// - Emits one-cycle registered pulses: pos_edge on 0->1, neg_edge on 1->0.
// - Used wherever an external or cross-domain level must become single-cycle events.
//
// PARAMETERS
// - SYNC_STAGES    2  synchroniser depth; legal values >= 2 (elaboration error if < 2)
// - FILTER_CYCLES  4  stability window in clocks for glitch filter; legal values >= 1;
//                     ignored unless EDGE_DETECT_FILTER_EN is defined
//
// PORTS
// - clk       in   1  system clock; all state updates on posedge
// - rst_n     in   1  reset; asynchronous assert, active-low
// - sig_in    in   1  level input; may be asynchronous to clk
// - pos_edge  out  1  one-cycle pulse on a detected rising edge; registered
// - neg_edge  out  1  one-cycle pulse on a detected falling edge; registered
//
// BEHAVIOUR
// Reset:
// - rst_n=0 immediately clears the sync chain, the previous-level flop, the filter
//   state, pos_edge and neg_edge to 0, independent of clk.
// - After release, sig_in is treated as having been 0 during reset. If sig_in is high
//   at release, exactly one pos_edge is produced after the normal latency.
//
// Datapath per posedge:
// - sync[0] <= sig_in; sync[i] <= sync[i-1].
// - lvl = sync[SYNC_STAGES-1], or the filtered level when the filter is built in.
// - prev <= lvl.
// - pos_edge <= lvl & ~prev.
// - neg_edge <= ~lvl & prev.
//
// Latency and pulse shape:
// - A level change first captured at posedge k drives the pulse high from posedge
//   k+SYNC_STAGES until posedge k+SYNC_STAGES+1. This is exactly one cycle.
// - With SYNC_STAGES=2, the pulse is high from k+2 to k+3.
// - pos_edge and neg_edge are never high in the same cycle.
// - A steady level produces no pulses.
//
// Boundary conditions:
// - A sig_in pulse that contains no posedge is not captured and produces no output.
//   Catching it is not required.
// - A pulse captured by exactly one posedge yields pos_edge, then neg_edge in the
//   immediately following cycle.
// - An input toggling every cycle yields alternating pos_edge and neg_edge pulses
//   every cycle.
// - Reset asserted mid-pulse forces both outputs to 0 at once.
// - No spurious pulses after reset while sig_in stays 0.
//
// CONFIGURATION
// - Macro EDGE_DETECT_FILTER_EN.
// - Defined:
//   - A glitch filter sits between sync[SYNC_STAGES-1] and lvl.
//   - A counter of width $clog2(FILTER_CYCLES+1) counts consecutive cycles in which
//     the synchronised input differs from the filtered level.
//   - The counter clears whenever they match.
//   - When the count reaches FILTER_CYCLES, the filtered level takes the new value
//     and the counter clears.
//   - Excursions shorter than FILTER_CYCLES clocks produce no pulse.
//   - Latency grows by FILTER_CYCLES cycles.
//   - Filtered level and counter reset to 0.
// - Undefined:
//   - lvl = sync[SYNC_STAGES-1] directly.
//   - No filter logic is present.
//
// TESTING
// - Clock period 10 ns; SYNC_STAGES=2; stimulus driven at negedge unless noted.
// - Hold rst_n=0 for 15 ns while toggling sig_in -> pos_edge=neg_edge=0 throughout.
// - After reset, sig_in 0->1 held 4 cycles -> pos_edge high exactly 1 cycle, starting
//   2 posedges after capture; neg_edge stays 0.
//   Then sig_in 1->0 -> neg_edge high exactly 1 cycle, same latency.
// - Drive a 2 ns high pulse placed entirely between posedges -> no pulse on either
//   output.
// - Drive a 2 ns pulse straddling one posedge -> pos_edge for 1 cycle, then neg_edge
//   for 1 cycle on the next cycle.
// - Assert rst_n=0 while pos_edge is high -> pos_edge drops to 0 before the next
//   posedge. After release with sig_in=1 -> exactly one pos_edge.
// - Build with EDGE_DETECT_FILTER_EN and FILTER_CYCLES=4:
//   - 2-cycle high glitch -> no pulses.
//   - 6-cycle high level -> one pos_edge, delayed by 4 extra cycles.

Source files
------------

// File: rtl/edge_detect.sv
// Rising/falling edge detector with a flop-chain synchroniser and registered one-cycle pulses.
// Define EDGE_DETECT_FILTER_EN to insert a glitch filter between the synchroniser and the detector.
module edge_detect #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic pos_edge,
   output logic neg_edge
);

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("edge_detect: SYNC_STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
      $error("edge_detect: FILTER_CYCLES must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_lvl;
   logic                   lvl;
   logic                   prev_q;
   logic                   pos_q;
   logic                   pos_d;
   logic                   neg_q;
   logic                   neg_d;

   // Reset to 0 makes a high input at release look like a fresh rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DETECT_FILTER_EN
   localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

   logic             filt_q;
   logic             filt_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The level flips on the FILTER_CYCLES-th consecutive differing sample.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_lvl != filt_q) begin
         if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
            filt_d = sync_lvl;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync_lvl;
`endif

   always_comb begin
      pos_d = lvl & ~prev_q;
      neg_d = ~lvl & prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         prev_q <= lvl;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign pos_edge = pos_q;
   assign neg_edge = neg_q;

endmodule

// File: tb/tb_edge_detect.sv
// Scoreboard bench for edge_detect: stimulus pushes expected pulses (kind, cycle), a monitor pops them.
module tb_edge_detect;

`ifdef EDGE_DETECT_FILTER_EN
   localparam int LAT = 3 + 4;
`else
   localparam int LAT = 3;
`endif

   typedef struct {
      bit is_pos;
      int at;
   } evt_t;

   logic clk;
   logic rst_n;
   logic sig_in;
   logic pos_edge;
   logic neg_edge;

   int   cyc;
   int   checks;
   int   failures;
   int   pulse_cnt;
   evt_t exp_q[$];

   edge_detect #(
      .SYNC_STAGES  (2),
      .FILTER_CYCLES(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig_in  (sig_in),
      .pos_edge(pos_edge),
      .neg_edge(neg_edge)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_evt(input bit is_pos, input int at);
      evt_t e;
      e.is_pos = is_pos;
      e.at     = at;
      exp_q.push_back(e);
   endtask

   task automatic check_evt(input bit is_pos);
      evt_t e;
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_pulse: got %s at cycle %0d, required no pulse",
                  is_pos ? "pos_edge" : "neg_edge", cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_pos != is_pos || e.at != cyc) begin
            failures++;
            $display("FAIL pulse_match: got %s at cycle %0d, required %s at cycle %0d",
                     is_pos ? "pos_edge" : "neg_edge", cyc,
                     e.is_pos ? "pos_edge" : "neg_edge", e.at);
         end
      end
   endtask

   // Monitor: sample 1 ns after each posedge.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         checks++;
         if (pos_edge || neg_edge) begin
            failures++;
            $display("FAIL reset_quiet: pos=%0b neg=%0b at cycle %0d, required 0 0",
                     pos_edge, neg_edge, cyc);
         end
      end else begin
         if (pos_edge && neg_edge) begin
            checks++;
            failures++;
            $display("FAIL both_high: pos=1 neg=1 at cycle %0d, required not both", cyc);
         end
         if (pos_edge) check_evt(1'b1);
         if (neg_edge) check_evt(1'b0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int  p0;
      bit  seen;
      checks    = 0;
      failures  = 0;
      pulse_cnt = 0;
      rst_n     = 1'b0;
      sig_in    = 1'b0;

      // Toggle the input through reset; outputs must stay low.
      for (int i = 0; i < 5; i++) begin
         #3 sig_in = ~sig_in;
         checks++;
         if (pos_edge || neg_edge) begin
            failures++;
            $display("FAIL reset_toggle: pos=%0b neg=%0b at %0t, required 0 0",
                     pos_edge, neg_edge, $time);
         end
      end
      @(negedge clk);
      sig_in = 1'b0;
      rst_n  = 1'b1;
      repeat (5) @(negedge clk);

`ifndef EDGE_DETECT_FILTER_EN
      // Rise held 4 cycles, then fall.
      @(negedge clk);
      sig_in = 1'b1;
      push_evt(1'b1, cyc + LAT);
      repeat (4) @(negedge clk);
      sig_in = 1'b0;
      push_evt(1'b0, cyc + LAT);
      repeat (6) @(negedge clk);

      // 2 ns pulse between posedges is never sampled.
      p0 = pulse_cnt;
      @(negedge clk);
      sig_in = 1'b1;
      #2 sig_in = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (pulse_cnt != p0) begin
         failures++;
         $display("FAIL narrow_pulse: got %0d pulses, required 0", pulse_cnt - p0);
      end

      // 2 ns pulse straddling one posedge.
      @(negedge clk);
      #4 sig_in = 1'b1;
      push_evt(1'b1, cyc + LAT);
      push_evt(1'b0, cyc + LAT + 1);
      #2 sig_in = 1'b0;
      repeat (6) @(negedge clk);

      // Toggle every cycle.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sig_in = ~sig_in;
         push_evt(sig_in, cyc + LAT);
      end
      repeat (6) @(negedge clk);
`else
      // 2-cycle glitch is absorbed by the filter.
      p0 = pulse_cnt;
      @(negedge clk);
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      sig_in = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (pulse_cnt != p0) begin
         failures++;
         $display("FAIL filter_glitch: got %0d pulses, required 0", pulse_cnt - p0);
      end

      // 6-cycle level passes with extra latency.
      @(negedge clk);
      sig_in = 1'b1;
      push_evt(1'b1, cyc + LAT);
      repeat (6) @(negedge clk);
      sig_in = 1'b0;
      push_evt(1'b0, cyc + LAT);
      repeat (12) @(negedge clk);
`endif

      // Reset asserted while pos_edge is high.
      @(negedge clk);
      sig_in = 1'b1;
      push_evt(1'b1, cyc + LAT);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (pos_edge) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL wait_pos_edge: got no pos_edge within 40 cycles, required one");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (pos_edge || neg_edge) begin
         failures++;
         $display("FAIL async_reset: pos=%0b neg=%0b, required 0 0", pos_edge, neg_edge);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_evt(1'b1, cyc + LAT);
      repeat (LAT + 4) @(negedge clk);
      sig_in = 1'b0;
      push_evt(1'b0, cyc + LAT);
      repeat (LAT + 6) @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_pulses: got %0d expected pulses never seen, required 0",
                  exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
